// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register stage with synchronous flush.
// Define PIPE_SKID_EN to add a skid entry that registers in_ready and cuts the out_ready path.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 96,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush
);

    logic accept;
    assign accept = in_valid && in_ready;

`ifdef PIPE_SKID_EN

    logic              skid_empty;
    logic [DATA_W-1:0] skid_data;

    // Ready comes straight from a flop, so out_ready never reaches in_ready combinationally.
    assign in_ready = skid_empty;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_empty <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_data   <= FLUSH_VAL;
            skid_empty <= 1'b1;
        end else if (!skid_empty) begin
            // Skid full implies main is full and no accept is possible this cycle.
            if (out_ready) begin
                out_data   <= skid_data;
                skid_empty <= 1'b1;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                skid_empty <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: payload-only storage needs no reset; its validity is carried by skid_empty.
    always_ff @(posedge clk) begin
        if (!flush && skid_empty && accept && out_valid && !out_ready) begin
            skid_data <= in_data;
        end
    end

`else

    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= FLUSH_VAL;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule
